// File: rtl/cpu_step_pkg.sv
// cpu_step_pkg: state encoding and build-time constants shared by cpu_step_ctrl
// and its input debouncers.
package cpu_step_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } step_state_e;

    // Board build: 10 ms debounce and roughly 190 Hz run pacing at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 1000000;
    localparam int unsigned RUN_DIV_LOG2_BOARD    = 19;

    // Simulation build: short windows so stepping and running are quick to exercise.
    localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;
    localparam int unsigned RUN_DIV_LOG2_SIM      = 3;

    localparam int unsigned STEP_CNT_W_DEFAULT    = 16;

    // Width needed to hold a debounce count of 0 .. cycles-1 (at least one bit).
    function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a level debouncer. A new level
// is accepted once the synchronized input has disagreed with the stable level
// for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import cpu_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam int unsigned       CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next synchronizer, counter and stable level.
    always_comb begin
        sync_d   = {sync_q[0], din};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: generates the cpu clock enable, either paced free-run or one
// pulse per debounced step press, and counts the pulses issued.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
    parameter int unsigned RUN_DIV_LOG2    = RUN_DIV_LOG2_BOARD,
    parameter int unsigned STEP_CNT_W      = STEP_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  btn_step,
    input  logic                  sw_run,
    output logic                  cpu_ena,
    output logic                  running,
    output logic [STEP_CNT_W-1:0] step_count
);

    logic btn_level;
    logic run_level;
    logic step_press;

    step_state_e             state_q, state_d;
    logic [RUN_DIV_LOG2-1:0] div_q, div_d;
    logic                    btn_prev_q, btn_prev_d;
    logic                    cpu_ena_q, cpu_ena_d;
    logic                    running_q, running_d;
    logic [STEP_CNT_W-1:0]   step_count_q, step_count_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_step),
        .level (btn_level)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .rst   (rst),
        .din   (sw_run),
        .level (run_level)
    );

    // A held button is a single press: only the debounced 0->1 edge counts.
    assign step_press = btn_level & ~btn_prev_q;

    // Next state, divider, pulse and counter values.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cpu_ena_d  = 1'b0;
        btn_prev_d = btn_level;
        unique case (state_q)
            HALT: begin
                // Run takes priority; a press not taken here is dropped.
                if (run_level && ena) begin
                    state_d = RUN;
                    div_d   = '0;
                end else if (step_press && ena) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                state_d   = HALT;
                cpu_ena_d = 1'b1;
            end
            RUN: begin
                if (!run_level) begin
                    state_d = HALT;
                    div_d   = '0;
                end else if (ena) begin
                    div_d     = div_q + RUN_DIV_LOG2'(1);
                    cpu_ena_d = (div_q == '1);
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
        running_d    = (state_d == RUN);
        step_count_d = step_count_q + STEP_CNT_W'(cpu_ena_d);
    end

    // FSM and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HALT;
            div_q        <= '0;
            btn_prev_q   <= 1'b0;
            cpu_ena_q    <= 1'b0;
            running_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            btn_prev_q   <= btn_prev_d;
            cpu_ena_q    <= cpu_ena_d;
            running_q    <= running_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_ena    = cpu_ena_q;
    assign running    = running_q;
    assign step_count = step_count_q;

endmodule
